// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MUSA core.
// Holds the fetch PC, selects the next PC from SEQ/BRANCH/JUMP/CALL/RET/HALT,
// drives push/pop strobes to the return-address stack and tracks its
// occupancy so that overflow/underflow halts the core with a sticky error.
//
// Handshake: an op is taken only when the sequencer is in RUN, instr_valid=1
// and stall=0. Otherwise the op is dropped and state holds. There is no
// back-pressure from the stack. stack_push/stack_pop are one-cycle strobes.
// After a push, stack_read_PC holds the pushed return address. After a pop,
// the stack presents the popped entry on stack_top one cycle later.
module pc_sequencer #(
  parameter int              WIDTH    = 18,
  parameter int              DEPTH    = 32768,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             instr_valid,
  input  logic [2:0]       op,
  input  logic             cond,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] stack_read_PC,
  output logic             stack_push,
  output logic             stack_pop,
  input  logic [WIDTH-1:0] stack_top,
  output logic             halted,
  output logic             stack_err
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_HALT   = 3'b101;

  // RET is split in two waits: RET_POP while the stack reads, RET_LOAD to
  // capture the popped value from stack_top.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_POP  = 2'd1,
    ST_RET_LOAD = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t           state;
  logic [OCC_W-1:0] occ;
  logic [WIDTH-1:0] pc_inc;
  logic             accept;

  // The next sequential address wraps naturally at 2^WIDTH.
  assign pc_inc = pc + WIDTH'(1);
  assign accept = (state == ST_RUN) && instr_valid && !stall;

  // Sequencer FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      pc            <= RESET_PC;
      pc_valid      <= 1'b1;
      stack_read_PC <= '0;
      stack_push    <= 1'b0;
      stack_pop     <= 1'b0;
      halted        <= 1'b0;
      stack_err     <= 1'b0;
      occ           <= '0;
    end else begin
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            case (op)
              OP_BRANCH: pc <= cond ? target : pc_inc;
              OP_JUMP:   pc <= target;
              OP_CALL: begin
                if (occ < OCC_MAX) begin
                  pc            <= target;
                  stack_read_PC <= pc_inc;
                  stack_push    <= 1'b1;
                  occ           <= occ + OCC_ONE;
                end else begin
                  // Overflow: leave pc where it is so the faulting CALL is visible.
                  stack_err <= 1'b1;
                  halted    <= 1'b1;
                  pc_valid  <= 1'b0;
                  state     <= ST_HALT;
                end
              end
              OP_RET: begin
                if (occ != '0) begin
                  stack_pop <= 1'b1;
                  occ       <= occ - OCC_ONE;
                  pc_valid  <= 1'b0;
                  state     <= ST_RET_POP;
                end else begin
                  stack_err <= 1'b1;
                  halted    <= 1'b1;
                  pc_valid  <= 1'b0;
                  state     <= ST_HALT;
                end
              end
              OP_HALT: begin
                halted   <= 1'b1;
                pc_valid <= 1'b0;
                state    <= ST_HALT;
              end
              default: pc <= pc_inc;  // SEQ and reserved encodings
            endcase
          end
        end
        ST_RET_POP: begin
          state <= ST_RET_LOAD;
        end
        ST_RET_LOAD: begin
          pc       <= stack_top;
          pc_valid <= 1'b1;
          state    <= ST_RUN;
        end
        default: begin
          // HALT absorbs everything until reset.
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized ops,
// checked every cycle against a transaction-level reference model.
// A small synchronous return-address stack model sits on the stack ports.
module tb_pc_sequencer;

  localparam int W = 18;
  localparam int D = 8;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          instr_valid;
  logic [2:0]    op;
  logic          cond;
  logic [W-1:0]  target;
  logic [W-1:0]  pc;
  logic          pc_valid;
  logic [W-1:0]  stack_read_PC;
  logic          stack_push;
  logic          stack_pop;
  logic [W-1:0]  stack_top;
  logic          halted;
  logic          stack_err;

  int n_total = 0;
  int n_bad   = 0;

  pc_sequencer #(.WIDTH(W), .DEPTH(D), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr_valid(instr_valid),
    .op(op), .cond(cond), .target(target), .pc(pc), .pc_valid(pc_valid),
    .stack_read_PC(stack_read_PC), .stack_push(stack_push),
    .stack_pop(stack_pop), .stack_top(stack_top), .halted(halted),
    .stack_err(stack_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit (got no finish, want finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- stack environment ----------------
  // Synchronous-read stack: the popped entry appears on stack_top next cycle.
  logic [W-1:0] stk_mem [0:D-1];
  int           stk_sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_sp    <= 0;
      stack_top <= '0;
    end else if (stack_push && stk_sp < D) begin
      stk_mem[stk_sp] <= stack_read_PC;
      stk_sp          <= stk_sp + 1;
    end else if (stack_pop && stk_sp > 0) begin
      stack_top <= stk_mem[stk_sp-1];
      stk_sp    <= stk_sp - 1;
    end
  end

  // ---------------- reference model ----------------
  logic [W-1:0] m_pc, m_rpc, m_ret;
  logic         m_valid, m_push, m_pop, m_halt, m_err;
  int           m_ret_wait;        // cycles left before the returned pc lands
  logic [W-1:0] m_stack[$];        // return addresses, back = top

  task automatic model_reset();
    m_pc = '0; m_rpc = '0; m_ret = '0;
    m_valid = 1'b1; m_push = 1'b0; m_pop = 1'b0;
    m_halt = 1'b0; m_err = 1'b0; m_ret_wait = 0;
    m_stack.delete();
  endtask

  task automatic model_fault();
    m_halt = 1'b1; m_err = 1'b1; m_valid = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    m_push = 1'b0;
    m_pop  = 1'b0;
    if (m_halt) begin
      // nothing moves
    end else if (m_ret_wait == 2) begin
      m_ret_wait = 1;
    end else if (m_ret_wait == 1) begin
      m_pc = m_ret; m_valid = 1'b1; m_ret_wait = 0;
    end else if (instr_valid && !stall) begin
      case (op)
        3'd1: m_pc = cond ? target : m_pc + 1'b1;
        3'd2: m_pc = target;
        3'd3: begin
          if (m_stack.size() < D) begin
            m_rpc = m_pc + 1'b1;
            m_stack.push_back(m_rpc);
            m_pc = target;
            m_push = 1'b1;
          end else model_fault();
        end
        3'd4: begin
          if (m_stack.size() > 0) begin
            m_ret = m_stack.pop_back();
            m_pop = 1'b1; m_valid = 1'b0; m_ret_wait = 2;
          end else model_fault();
        end
        3'd5: begin m_halt = 1'b1; m_valid = 1'b0; end
        default: m_pc = m_pc + 1'b1;
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h want=%h", tag, $time, got, want);
    end
  endtask

  task automatic check_all();
    chk("pc",        32'(pc),            32'(m_pc));
    chk("pc_valid",  32'(pc_valid),      32'(m_valid));
    chk("read_pc",   32'(stack_read_PC), 32'(m_rpc));
    chk("push",      32'(stack_push),    32'(m_push));
    chk("pop",       32'(stack_pop),     32'(m_pop));
    chk("halted",    32'(halted),        32'(m_halt));
    chk("stack_err", 32'(stack_err),     32'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic [2:0] o, input logic c, input logic [W-1:0] t,
                       input logic v, input logic s);
    op = o; cond = c; target = t; instr_valid = v; stall = s;
    step();
  endtask

  // Asserted mid-cycle so the asynchronous effect is checked before any edge.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; stall = 1'b0; instr_valid = 1'b0; op = '0; cond = 1'b0; target = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // T1: three sequential ops
    repeat (3) drive(3'd0, 1'b0, '0, 1'b1, 1'b0);
    chk("t1_pc3", 32'(pc), 32'd3);

    // T2/T3: CALL from pc=5, then RET with pops checked on the following cycles
    do_reset();
    repeat (5) drive(3'd0, 1'b0, '0, 1'b1, 1'b0);
    drive(3'd3, 1'b0, 18'h100, 1'b1, 1'b0);
    chk("t2_rpc", 32'(stack_read_PC), 32'd6);
    drive(3'd0, 1'b0, '0, 1'b0, 1'b0);
    drive(3'd4, 1'b0, '0, 1'b1, 1'b0);
    chk("t3_pop", 32'(stack_pop), 32'd1);
    drive(3'd2, 1'b0, 18'h3, 1'b1, 1'b0);   // ignored while returning
    drive(3'd2, 1'b0, 18'h3, 1'b1, 1'b1);
    drive(3'd0, 1'b0, '0, 1'b0, 1'b0);
    chk("t3_pc", 32'(pc), 32'd6);

    // T4: RET at empty stack halts; later ops ignored
    do_reset();
    drive(3'd4, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(3'($urandom_range(0, 7)), 1'b1, 18'h55, 1'b1, 1'b0);
    chk("t4_err", 32'(stack_err), 32'd1);
    do_reset();

    // T5: wrap and branches
    drive(3'd2, 1'b0, 18'h3FFFF, 1'b1, 1'b0);
    drive(3'd0, 1'b0, '0, 1'b1, 1'b0);
    chk("t5_wrap", 32'(pc), 32'd0);
    drive(3'd2, 1'b0, 18'd7, 1'b1, 1'b0);
    drive(3'd1, 1'b0, 18'h20, 1'b1, 1'b0);
    drive(3'd1, 1'b1, 18'h20, 1'b1, 1'b0);
    chk("t5_br", 32'(pc), 32'h20);

    // T6: stalled CALL, then reset in the pop cycle
    repeat (4) drive(3'd3, 1'b0, 18'h1234, 1'b1, 1'b1);
    drive(3'd3, 1'b0, 18'h1234, 1'b1, 1'b0);
    drive(3'd0, 1'b0, '0, 1'b0, 1'b0);
    drive(3'd4, 1'b0, '0, 1'b1, 1'b0);
    do_reset();
    chk("t6_pop_rst", 32'(stack_pop), 32'd0);

    // Overflow: fill the stack, then one more CALL
    for (int i = 0; i < D + 1; i++) drive(3'd3, 1'b0, 18'(i * 16 + 3), 1'b1, 1'b0);
    chk("ovf_halt", 32'(halted), 32'd1);
    repeat (3) drive(3'd0, 1'b0, '0, 1'b1, 1'b0);
    do_reset();

    // Randomized ops; reset a few cycles after any halt
    begin
      int halt_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
        int r = int'($urandom_range(0, 99));
        logic [2:0] o;
        if (r < 15)      o = 3'd3;
        else if (r < 27) o = 3'd4;
        else if (r < 29) o = 3'd5;
        else             o = 3'($urandom_range(0, 7)) & ((r[0]) ? 3'd7 : 3'd2);
        drive(o, 1'($urandom_range(0, 1)), 18'($urandom), 1'($urandom_range(0, 4) != 0),
              1'($urandom_range(0, 4) == 0));
        if (m_halt) halt_cnt++;
        if (halt_cnt > 2 || $urandom_range(0, 199) == 0) begin
          halt_cnt = 0;
          do_reset();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
